// File: rtl/stack_ctrl.sv
// Command sequencer for a single-port stack: checks legality against the stack count and
// splits each command into single push/pop cycles. Optional MUL opcode under STACK_CTRL_MUL_EN.
module stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic             err,
  output logic             err_sticky,
  output logic [WIDTH-1:0] res,
  output logic             st_push,
  output logic             st_pop,
  output logic [WIDTH-1:0] st_data,
  input  logic [WIDTH-1:0] st_top,
  input  logic [DEPTH-1:0] st_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP_A  = 3'd1;
  localparam logic [2:0] S_POP_B  = 3'd2;
  localparam logic [2:0] S_PUSH_1 = 3'd3;
  localparam logic [2:0] S_PUSH_2 = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_DROP = 3'd1;
  localparam logic [2:0] OP_DUP  = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam logic [DEPTH-1:0] C_TWO  = DEPTH'(2);
  localparam logic [DEPTH-1:0] C_FULL = {DEPTH{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_done;
  logic             r_err;
  logic             r_err_sticky;
  logic [WIDTH-1:0] r_res;

  logic [2:0]       w_state_nx;
  logic             w_accept;
  logic             w_illegal;
  logic             w_has1;
  logic             w_has2;
  logic             w_room;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_st_data;

`ifdef STACK_CTRL_MUL_EN
  logic [WIDTH-1:0] w_mul;
  assign w_mul = r_b * r_a;
`endif

  assign cmd_ready  = (r_state == S_IDLE);
  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign st_push    = (r_state == S_PUSH_1) || (r_state == S_PUSH_2);
  assign st_pop     = (r_state == S_POP_A) || (r_state == S_POP_B);
  assign st_data    = w_st_data;
  assign done       = r_done;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  // The stack shows its updated top only in the done cycle itself, so it is passed
  // through then and held in r_res afterwards.
  assign res        = r_done ? st_top : r_res;

  // Legality of the presented opcode against the current stack occupancy.
  always_comb begin
    w_has1    = (st_count != {DEPTH{1'b0}});
    w_has2    = (st_count >= C_TWO);
    w_room    = (st_count != C_FULL);
    w_illegal = 1'b0;
    case (cmd_op)
      OP_PUSH:                         w_illegal = !w_room;
      OP_DROP:                         w_illegal = !w_has1;
      OP_DUP:                          w_illegal = !(w_has1 && w_room);
      OP_SWAP, OP_ADD, OP_SUB, OP_XOR: w_illegal = !w_has2;
`ifdef STACK_CTRL_MUL_EN
      OP_MUL:                          w_illegal = !w_has2;
`else
      OP_MUL:                          w_illegal = 1'b1;
`endif
      default:                         w_illegal = 1'b1;
    endcase
  end

  // Next-state sequencing of the per-command stack cycles.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_state_nx = S_IDLE;
        end else if (w_illegal) begin
          w_state_nx = S_DONE;
        end else if ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) begin
          w_state_nx = S_PUSH_1;
        end else begin
          w_state_nx = S_POP_A;
        end
      end
      S_POP_A: begin
        if (r_op == OP_DROP) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_POP_B;
        end
      end
      S_POP_B:  w_state_nx = S_PUSH_1;
      S_PUSH_1: begin
        if (r_op == OP_SWAP) begin
          w_state_nx = S_PUSH_2;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      S_PUSH_2: w_state_nx = S_DONE;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Binary operation result, B is the deeper operand.
  always_comb begin
    w_alu = {WIDTH{1'b0}};
    case (r_op)
      OP_ADD:  w_alu = r_b + r_a;
      OP_SUB:  w_alu = r_b - r_a;
      OP_XOR:  w_alu = r_b ^ r_a;
`ifdef STACK_CTRL_MUL_EN
      OP_MUL:  w_alu = w_mul;
`endif
      default: w_alu = {WIDTH{1'b0}};
    endcase
  end

  // Data presented to the stack in the push states.
  always_comb begin
    w_st_data = {WIDTH{1'b0}};
    case (r_state)
      S_PUSH_1: begin
        case (r_op)
          OP_PUSH: w_st_data = r_imm;
          OP_DUP:  w_st_data = st_top;
          OP_SWAP: w_st_data = r_a;
          default: w_st_data = w_alu;
        endcase
      end
      S_PUSH_2: w_st_data = r_b;
      default:  w_st_data = {WIDTH{1'b0}};
    endcase
  end

  // State, latched command, operands and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_imm        <= {WIDTH{1'b0}};
      r_a          <= {WIDTH{1'b0}};
      r_b          <= {WIDTH{1'b0}};
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_res        <= {WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_op  <= cmd_op;
        r_imm <= cmd_imm;
      end
      if (r_state == S_POP_A) begin
        r_a <= st_top;
      end
      if (r_state == S_POP_B) begin
        r_b <= st_top;
      end
      r_done <= (w_state_nx == S_DONE);
      r_err  <= w_accept && w_illegal;
      if (w_accept && w_illegal) begin
        r_err_sticky <= 1'b1;
      end
      if (r_done) begin
        r_res <= st_top;
      end
    end
  end

endmodule
